// File: rtl/vga_pixel_stage_if.sv
// Framebuffer read port between the pixel stage (master) and the framebuffer (slave).
interface vga_pixel_stage_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    logic [11:0]       fb_data;

    modport master (output fb_addr, output fb_rd_en, input fb_data);
    modport slave  (input fb_addr, input fb_rd_en, output fb_data);
endinterface

// File: rtl/vga_pixel_stage.sv
// Pixel datapath after the VGA timing controller: framebuffer addressing, read-latency
// alignment of sync/colour, hollow-box cursor overlay and a once-per-frame pulse.
module vga_pixel_stage #(
    parameter int FB_LATENCY  = 2,
    parameter int SCALE_SHIFT = 1,
    parameter int FB_WIDTH    = 320,
    parameter int ADDR_W      = 17,
    parameter int CURSOR_SIZE = 8
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              clk_25MHz,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              xyvalid_in,
    input  logic [9:0]        x_in,
    input  logic [9:0]        y_in,
    vga_pixel_stage_if.master fb,
    input  logic [9:0]        cursor_x,
    input  logic [9:0]        cursor_y,
    input  logic              cursor_en,
    input  logic [11:0]       cursor_color,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              frame_pulse
);
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        valid;
        logic        hit;
        logic [11:0] color;
    } sideband_t;

    localparam sideband_t   SB_IDLE  = '{hs: 1'b1, vs: 1'b1, valid: 1'b0, hit: 1'b0, color: 12'h000};
    localparam logic [10:0] BOX_LAST = 11'(CURSOR_SIZE - 1);

    logic [9:0]        sh_x;
    logic [9:0]        sh_y;
    logic              sh_en;
    logic [11:0]       sh_color;
    logic              vsync_prev;
    logic              frame_start;
    logic [ADDR_W-1:0] addr_next;
    logic [10:0]       px;
    logic [10:0]       py;
    logic [10:0]       x_lo;
    logic [10:0]       x_hi;
    logic [10:0]       y_lo;
    logic [10:0]       y_hi;
    logic              hit;
    sideband_t         sb_in;
    sideband_t         sb_last;
    sideband_t         sb_pipe [FB_LATENCY];
    logic              hs_s;
    logic              vs_s;
    logic [11:0]       pix_s;

    // 11-bit compares so a box hanging off the right/bottom edge clips instead of wrapping.
    always_comb begin
        addr_next   = ADDR_W'(32'(y_in >> SCALE_SHIFT) * 32'(FB_WIDTH) + 32'(x_in >> SCALE_SHIFT));
        frame_start = vsync_prev & ~vsync_in;
        px          = {1'b0, x_in};
        py          = {1'b0, y_in};
        x_lo        = {1'b0, sh_x};
        y_lo        = {1'b0, sh_y};
        x_hi        = x_lo + BOX_LAST;
        y_hi        = y_lo + BOX_LAST;
        hit         = sh_en && (px >= x_lo) && (px <= x_hi) && (py >= y_lo) && (py <= y_hi)
                      && ((px == x_lo) || (px == x_hi) || (py == y_lo) || (py == y_hi));
        sb_in       = '{hs: hsync_in, vs: vsync_in, valid: xyvalid_in, hit: hit, color: sh_color};
        sb_last     = sb_pipe[FB_LATENCY-1];
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            fb.fb_addr  <= '0;
            fb.fb_rd_en <= 1'b0;
            vsync_prev  <= 1'b1;
            sh_x        <= '0;
            sh_y        <= '0;
            sh_en       <= 1'b0;
            sh_color    <= '0;
        end else if (clk_25MHz) begin
            if (xyvalid_in) begin
                fb.fb_addr <= addr_next;
            end
            fb.fb_rd_en <= xyvalid_in;
            vsync_prev  <= vsync_in;
            // Cursor state only changes at vsync start so a frame never shows a torn box.
            if (frame_start) begin
                sh_x     <= cursor_x;
                sh_y     <= cursor_y;
                sh_en    <= cursor_en;
                sh_color <= cursor_color;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            frame_pulse <= 1'b0;
        end else begin
            frame_pulse <= clk_25MHz & frame_start;
        end
    end

    // The colour travels with the hit flag so in-flight pixels keep the shadow they saw.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < FB_LATENCY; i++) begin
                sb_pipe[i] <= SB_IDLE;
            end
        end else if (clk_25MHz) begin
            sb_pipe[0] <= sb_in;
            for (int i = 1; i < FB_LATENCY; i++) begin
                sb_pipe[i] <= sb_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hs_s  <= 1'b1;
            vs_s  <= 1'b1;
            pix_s <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (clk_25MHz) begin
            hs_s  <= sb_last.hs;
            vs_s  <= sb_last.vs;
            pix_s <= !sb_last.valid ? 12'h000 : (sb_last.hit ? sb_last.color : fb.fb_data);
            hsync <= hs_s;
            vsync <= vs_s;
            red   <= pix_s[11:8];
            green <= pix_s[7:4];
            blue  <= pix_s[3:0];
        end
    end
endmodule

// File: doc/vga_pixel_stage.md
# vga_pixel_stage

Pixel-datapath stage directly downstream of the VGA timing controller. Each pixel strobe it takes raw scan position and sync, turns the position into a framebuffer read address, and waits out the framebuffer read latency. It then emits registered 4:4:4 RGB with a hollow-box paint cursor overlaid. hsync/vsync are delayed by the same pipeline depth so colour and sync stay aligned at the connector, and a once-per-frame pulse lets the paint logic update cursor state without tearing.

## Interface
- FB_LATENCY, 2: strobes from fb_addr registration to fb_data sampling (≥1)
- SCALE_SHIFT, 1: screen-to-framebuffer downscale (1 → 320×240 framebuffer)
- FB_WIDTH, 320: framebuffer row length in words
- ADDR_W, 17: framebuffer address width
- CURSOR_SIZE, 8: cursor box edge in screen pixels (≥2)
- clk  in  1  master clock; only clock in the block
- clr_n  in  1  asynchronous, active-low reset
- clk_25MHz  in  1  pixel strobe, synchronous to clk; all state advances only when high
- hsync_in, vsync_in  in  1 each  active-low syncs from timing controller
- xyvalid_in  in  1  active-video qualifier
- x_in, y_in  in  10 each  scan position, 0..639 / 0..479 when xyvalid_in
- fb_addr  out  ADDR_W  framebuffer read address
- fb_rd_en  out  1  read enable, high for visible pixels
- fb_data  in  12  pixel word {R[3:0],G[3:0],B[3:0]}
- cursor_x, cursor_y  in  10 each  cursor top-left, screen coordinates
- cursor_en  in  1  cursor visible
- cursor_color  in  12  cursor colour
- hsync, vsync  out  1 each  delayed syncs to connector
- red, green, blue  out  4 each  pixel colour
- frame_pulse  out  1  one-clk pulse at start of vsync

## Operation
- Reset (clr_n=0, async): hsync=vsync=1, RGB=0, fb_rd_en=0, fb_addr=0, frame_pulse=0. Delay lines hold blank, sync-high. Cursor shadow is cleared (en=0).
- clk_25MHz=0: every register holds. Exception: frame_pulse returns to 0.
- Stage A (strobe N), from inputs:
  - fb_addr = (y_in>>SCALE_SHIFT)*FB_WIDTH + (x_in>>SCALE_SHIFT), truncated to ADDR_W.
  - Registered only when xyvalid_in=1; otherwise fb_addr holds its value.
  - fb_rd_en = xyvalid_in.
- Cursor hit (stage A), from shadow registers, using 11-bit compares (no wrap):
  - The pixel lies inside [cx, cx+CURSOR_SIZE) × [cy, cy+CURSOR_SIZE), and
  - x==cx, or x==cx+CURSOR_SIZE-1, or y==cy, or y==cy+CURSOR_SIZE-1.
  - Off-screen portions are simply clipped.
- Sideband {hsync_in, vsync_in, xyvalid_in, hit} passes through a delay line of FB_LATENCY strobes.
- Output stage (strobe N+FB_LATENCY): fb_data is sampled, then:
  - delayed valid=0 → RGB=0;
  - else hit → cursor colour;
  - else fb_data.
  - Syncs are output from the same delay line.
- Frame boundary:
  - Condition: a strobe where vsync_in=0 and the previous strobe's vsync_in=1.
  - That strobe loads shadow {cx, cy, en, color} from the cursor inputs.
  - frame_pulse is high for exactly the next clk.
  - Pixels in flight during the load use the old shadow (they are blanked anyway).
- Cursor input changes mid-frame never affect the current frame.
- Reset mid-frame flushes the pipeline. After release, outputs are blank/sync-high until real data reaches the output stage.

## Timing
- Latency L = FB_LATENCY+1 strobes. Input sampled at strobe N appears on hsync/vsync/RGB after strobe N+L.
- Syncs and RGB have identical latency, so edge alignment relative to active video is preserved.
- fb_data contract: the word for the address registered at strobe N must be stable when strobe N+FB_LATENCY occurs.
- frame_pulse: period 800×521 strobes in steady state.
- Throughput: one pixel per strobe, no backpressure.

## Test plan
- Reset: drive clr_n=0 mid-active-line. Immediately hsync=vsync=1, RGB=0, fb_rd_en=0. After release with valid pixels, the first nonzero RGB appears after strobe L=3.
- Address: these (x,y) inputs map to fb_addr as follows, with fb_rd_en=1:
  - (0,0) → 0
  - (3,2) → 321
  - (639,479) → 76799
- Alignment: the fb model returns 12'hABC with latency 2. A valid pixel at strobe N gives red=A, green=B, blue=C after strobe N+3. An hsync_in falling edge at strobe M gives hsync falling after strobe M+3.
- Blanking: xyvalid_in=0 with fb_data=12'hFFF gives RGB=0 and fb_rd_en=0, with fb_addr unchanged.
- Cursor at edge: cursor_x=636, cursor_y=100, cursor_en=1, colour F00, latched by frame_pulse.
  - Pixels (636,100..107) and (636..639,100) output F00.
  - Pixel (637,101) outputs fb_data.
  - x=0..3 is never hit (no wrap).
  - Changing cursor_x mid-frame takes effect only in the next frame.
- Frame pulse and stall:
  - Exactly one one-clk frame_pulse per frame, spaced 416800 strobes apart.
  - Holding clk_25MHz=0 for 5 clks freezes all outputs and fb_addr.
